// File: rtl/radix8_input_feeder_pkg.sv
// Shared constants for the radix-8 input feeder: default sizes, slot limits and read-FSM encodings.
package radix8_input_feeder_pkg;
   localparam int DEF_WIDTH      = 16;
   localparam int DEF_NUM_GROUPS = 64;
   localparam int DEF_GRP_W      = 6;
   localparam int RADIX          = 8;
   localparam int NUM_TW         = 7;
   localparam int SLOT_W         = 3;

   localparam logic [SLOT_W-1:0] SLOT_FIRST = 3'd0;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = 3'd7;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
endpackage

// File: rtl/radix8_gather_bank.sv
// One 8-word gather bank: slot-addressed write port, full flag, and group-index / mode tags.
module radix8_gather_bank
   import radix8_input_feeder_pkg::*;
#(
   parameter int width = DEF_WIDTH,
   parameter int GRP_W = DEF_GRP_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [SLOT_W-1:0]      i_slot,
   input  logic [width-1:0]       i_wr_data,
   input  logic                   i_mode,
   input  logic [GRP_W-1:0]       i_grp,
   input  logic                   i_clr,
   output logic                   o_full,
   output logic [RADIX*width-1:0] o_data,
   output logic [GRP_W-1:0]       o_grp,
   output logic                   o_mode
);
   logic [width-1:0] r_mem [RADIX];
   logic             r_full;
   logic [GRP_W-1:0] r_grp;
   logic             r_mode;
   logic             w_first;
   logic             w_last;

   assign w_first = i_wr_en && (i_slot == SLOT_FIRST);
   assign w_last  = i_wr_en && (i_slot == SLOT_LAST);

   // coefficient storage; contents are only meaningful while full
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_slot] <= i_wr_data;
      end
   end

   // mode is tagged on slot 0, group index and full on slot 7
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full <= 1'b0;
         r_grp  <= '0;
         r_mode <= 1'b0;
      end else begin
         if (i_clr) begin
            r_full <= 1'b0;
         end else if (w_last) begin
            r_full <= 1'b1;
         end
         if (w_first) begin
            r_mode <= i_mode;
         end
         if (w_last) begin
            r_grp <= i_grp;
         end
      end
   end

   // flatten the bank into the parallel output word
   always_comb begin
      o_data = '0;
      for (int k = 0; k < RADIX; k++) begin
         o_data[k*width +: width] = r_mem[k];
      end
   end

   assign o_full = r_full;
   assign o_grp  = r_grp;
   assign o_mode = r_mode;
endmodule

// File: rtl/radix8_input_feeder.sv
// Radix-8 butterfly input feeder: gathers 8-word groups into ping-pong banks, fetches twiddles, hands off in parallel.
// Optional group counter / stage_done outputs are enabled by defining RADIX8_FEED_CNT_EN.
module radix8_input_feeder
   import radix8_input_feeder_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int NUM_GROUPS = DEF_NUM_GROUPS,
   parameter int GRP_W      = DEF_GRP_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [width-1:0]        in_data,
   input  logic                    mode,
   output logic [GRP_W-1:0]        tw_addr,
   input  logic [NUM_TW*width-1:0] tw_rdata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RADIX*width-1:0]  out_data,
   output logic [NUM_TW*width-1:0] out_tw,
   output logic                    out_select
`ifdef RADIX8_FEED_CNT_EN
   ,
   output logic [GRP_W-1:0]        grp_cnt,
   output logic                    stage_done
`endif
);
   logic [SLOT_W-1:0]        r_slot;
   logic                     r_wr_bank;
   logic                     r_rd_bank;
   logic [GRP_W-1:0]         r_wr_grp;
   logic [1:0]               r_state;
   logic                     r_out_valid;
   logic [RADIX*width-1:0]   r_out_data;
   logic [NUM_TW*width-1:0]  r_out_tw;
   logic                     r_out_select;

   logic                     w_in_acc;
   logic                     w_out_hs;
   logic [1:0]               w_wr_en;
   logic [1:0]               w_clr;
   logic [1:0]               w_full;
   logic [RADIX*width-1:0]   w_bank_data [2];
   logic [GRP_W-1:0]         w_bank_grp  [2];
   logic                     w_bank_mode [2];

   assign in_ready = !w_full[r_wr_bank];
   assign w_in_acc = in_valid && in_ready;
   assign w_out_hs = r_out_valid && out_ready;
   // the ROM registers this address, so it must already point at the next bank before FETCH
   assign tw_addr  = w_bank_grp[r_rd_bank];

   // route accepted beats to the write bank and the FETCH clear to the read bank
   always_comb begin
      w_wr_en = 2'b00;
      w_clr   = 2'b00;
      if (w_in_acc) begin
         w_wr_en[r_wr_bank] = 1'b1;
      end else begin
         w_wr_en = 2'b00;
      end
      if (r_state == ST_FETCH) begin
         w_clr[r_rd_bank] = 1'b1;
      end else begin
         w_clr = 2'b00;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      radix8_gather_bank #(
         .width (width),
         .GRP_W (GRP_W)
      ) u_bank (
         .i_clk     (clk),
         .i_rst     (rst),
         .i_wr_en   (w_wr_en[b]),
         .i_slot    (r_slot),
         .i_wr_data (in_data),
         .i_mode    (mode),
         .i_grp     (r_wr_grp),
         .i_clr     (w_clr[b]),
         .o_full    (w_full[b]),
         .o_data    (w_bank_data[b]),
         .o_grp     (w_bank_grp[b]),
         .o_mode    (w_bank_mode[b])
      );
   end

   // write side: slot pointer, bank toggle and wrapping group index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot    <= SLOT_FIRST;
         r_wr_bank <= 1'b0;
         r_wr_grp  <= '0;
      end else if (w_in_acc) begin
         r_slot <= r_slot + 3'd1;
         if (r_slot == SLOT_LAST) begin
            r_wr_bank <= ~r_wr_bank;
            if (r_wr_grp == GRP_W'(NUM_GROUPS - 1)) begin
               r_wr_grp <= '0;
            end else begin
               r_wr_grp <= r_wr_grp + GRP_W'(1);
            end
         end
      end
   end

   // read FSM and registered parallel outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rd_bank    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_tw     <= '0;
         r_out_select <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_full[r_rd_bank]) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               r_out_data   <= w_bank_data[r_rd_bank];
               r_out_tw     <= tw_rdata;
               r_out_select <= w_bank_mode[r_rd_bank];
               r_out_valid  <= 1'b1;
               r_rd_bank    <= ~r_rd_bank;
               r_state      <= ST_HOLD;
            end
            ST_HOLD: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_state     <= w_full[r_rd_bank] ? ST_FETCH : ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_tw     = r_out_tw;
   assign out_select = r_out_select;

`ifdef RADIX8_FEED_CNT_EN
   logic [GRP_W-1:0] r_grp_cnt;
   logic             r_stage_done;

   // count handed-off groups; stage_done pulses on the wrap back to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grp_cnt    <= '0;
         r_stage_done <= 1'b0;
      end else if (w_out_hs) begin
         if (r_grp_cnt == GRP_W'(NUM_GROUPS - 1)) begin
            r_grp_cnt    <= '0;
            r_stage_done <= 1'b1;
         end else begin
            r_grp_cnt    <= r_grp_cnt + GRP_W'(1);
            r_stage_done <= 1'b0;
         end
      end else begin
         r_stage_done <= 1'b0;
      end
   end

   assign grp_cnt    = r_grp_cnt;
   assign stage_done = r_stage_done;
`endif
endmodule

// File: tb/tb_radix8_input_feeder.sv
// Self-checking bench for radix8_input_feeder: directed scenarios plus randomized throttling vs a queue model.
module tb_radix8_input_feeder;
   localparam int W  = 16;
   localparam int NG = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic           mode = 1'b0;
   logic [5:0]     tw_addr;
   logic [7*W-1:0] tw_rdata = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [8*W-1:0] out_data;
   logic [7*W-1:0] out_tw;
   logic           out_select;
`ifdef RADIX8_FEED_CNT_EN
   logic [5:0]     grp_cnt;
   logic           stage_done;
   int             n_sd = 0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   radix8_input_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .mode       (mode),
      .tw_addr    (tw_addr),
      .tw_rdata   (tw_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tw     (out_tw),
      .out_select (out_select)
`ifdef RADIX8_FEED_CNT_EN
      ,
      .grp_cnt    (grp_cnt),
      .stage_done (stage_done)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7*W-1:0] tw_pat(input int g);
      logic [7*W-1:0] r;
      for (int k = 0; k < 7; k++) r[k*W +: W] = 16'h5000 + 16'(g * 16) + 16'(k);
      return r;
   endfunction

   // synchronous twiddle ROM with one-cycle latency
   always @(posedge clk) tw_rdata <= tw_pat(int'(tw_addr));

   typedef struct { logic [8*W-1:0] data; logic [7*W-1:0] tw; logic sel; } rx_t;
   typedef struct { logic [8*W-1:0] data; int grp; logic sel; } ex_t;
   rx_t rx_q[$];
   ex_t exp_q[$];
   ex_t done_q[$];
   logic [8*W-1:0] m_cur;
   int m_slot = 0, m_grp = 0, underflow = 0;
   logic m_mode = 1'b0;

   // reference model: groups of 8 accepted words in order, group index modulo NG
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_slot = 0;
         m_grp  = 0;
      end else begin
         if (out_valid && out_ready) begin
            rx_q.push_back('{out_data, out_tw, out_select});
            if (exp_q.size() > 0) done_q.push_back(exp_q.pop_front());
            else underflow++;
         end
         if (in_valid && in_ready) begin
            if (m_slot == 0) m_mode = mode;
            m_cur[m_slot*W +: W] = in_data;
            m_slot++;
            if (m_slot == 8) begin
               exp_q.push_back('{m_cur, m_grp, m_mode});
               m_slot = 0;
               m_grp  = (m_grp + 1) % NG;
            end
         end
`ifdef RADIX8_FEED_CNT_EN
         if (stage_done) n_sd++;
`endif
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rx_q.delete(); done_q.delete(); underflow = 0;
   endtask

   task automatic send_word(input logic [W-1:0] d, input logic md);
      bit rdy, ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; mode = md;
      for (int t = 0; t < 300; t++) begin
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL send_word: word %h not accepted, required acceptance within 300 cycles", d); end
   endtask

   task automatic go_idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int limit);
      for (int t = 0; t < limit && rx_q.size() < n; t++) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || tw_addr !== 6'd0) begin
         n_fail++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b tw_addr=%0d, required 1 0 0", in_ready, out_valid, tw_addr);
      end
      n_checks++;
      if (out_data !== '0 || out_tw !== '0 || out_select !== 1'b0) begin
         n_fail++; $display("FAIL reset_data: data=%h tw=%h sel=%b, required zeros", out_data, out_tw, out_select);
      end
   endtask

   task automatic test_single();
      logic [8*W-1:0] ed;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 16'(i + 1); mode = 1'b0;
         ed[i*W +: W] = 16'(i + 1);
      end
      @(negedge clk); in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n: out_valid=%b after edge N, required 0", out_valid); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: out_valid=%b after edge N+1, required 0", out_valid); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n2: out_valid=%b after edge N+2, required 1", out_valid); end
      n_checks++;
      if (out_data !== ed || out_tw !== tw_pat(0) || out_select !== 1'b0) begin
         n_fail++; $display("FAIL single_data: data=%h tw=%h sel=%b, required %h %h 0", out_data, out_tw, out_select, ed, tw_pat(0));
      end
      wait_rx(1, 20);
      n_checks++;
      if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d groups, required 1", rx_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [8*W-1:0] ed;
      apply_reset();
      for (int i = 0; i < 24; i++) send_word(16'(100 + i), 1'b0);
      @(negedge clk);
      in_data = 16'hDEAD;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: in_ready=%b with 3 groups buffered, required 0", in_ready); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_rx(3, 100);
      repeat (10) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d groups, required 3", rx_q.size()); end
      for (int g = 0; g < 3 && g < rx_q.size(); g++) begin
         for (int k = 0; k < 8; k++) ed[k*W +: W] = 16'(100 + 8*g + k);
         n_checks++;
         if (rx_q[g].data !== ed || rx_q[g].tw !== tw_pat(g)) begin
            n_fail++; $display("FAIL bp_group%0d: data=%h tw=%h, required %h %h", g, rx_q[g].data, rx_q[g].tw, ed, tw_pat(g));
         end
      end
   endtask

   task automatic test_mode();
      apply_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) send_word(16'($urandom), (k < 3) ? 1'b1 : 1'b0);
      for (int k = 0; k < 8; k++) send_word(16'($urandom), (k >= 5) ? 1'b1 : 1'b0);
      go_idle();
      wait_rx(2, 100);
      n_checks++;
      if (rx_q.size() != 2) begin
         n_fail++; $display("FAIL mode_count: got %0d groups, required 2", rx_q.size());
      end else begin
         n_checks++;
         if (rx_q[0].sel !== 1'b1 || rx_q[1].sel !== 1'b0) begin
            n_fail++; $display("FAIL mode_sel: sel=%b,%b, required 1,0", rx_q[0].sel, rx_q[1].sel);
         end
         n_checks++;
         if (rx_q[0].data !== done_q[0].data || rx_q[1].data !== done_q[1].data) begin
            n_fail++; $display("FAIL mode_data: data=%h, required %h", rx_q[1].data, done_q[1].data);
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
`ifdef RADIX8_FEED_CNT_EN
      n_sd = 0;
`endif
      out_ready = 1'b1;
      for (int g = 0; g < NG + 1; g++)
         for (int k = 0; k < 8; k++) send_word(16'($urandom), 1'b0);
      go_idle();
      wait_rx(NG + 1, 400);
      n_checks++;
      if (rx_q.size() != NG + 1) begin
         n_fail++; $display("FAIL wrap_count: got %0d groups, required %0d", rx_q.size(), NG + 1);
      end else begin
         for (int i = 0; i < NG + 1; i++) begin
            n_checks++;
            if (rx_q[i].tw !== tw_pat(i % NG) || rx_q[i].data !== done_q[i].data) begin
               n_fail++; $display("FAIL wrap_group%0d: tw=%h data=%h, required %h %h", i, rx_q[i].tw, rx_q[i].data, tw_pat(i % NG), done_q[i].data);
            end
         end
      end
`ifdef RADIX8_FEED_CNT_EN
      repeat (3) @(negedge clk);
      n_checks++;
      if (n_sd != 1 || grp_cnt !== 6'd1) begin
         n_fail++; $display("FAIL wrap_cnt: stage_done pulses=%0d grp_cnt=%0d, required 1 1", n_sd, grp_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [8*W-1:0] ed;
      apply_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) send_word(16'(16'h0100 + k), 1'b0);
      go_idle();
      wait_rx(1, 50);
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) send_word(16'(16'h0200 + k), 1'b1);
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
      for (int k = 0; k < 5; k++) send_word(16'(16'h0300 + k), 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || tw_addr !== 6'd0) begin
         n_fail++; $display("FAIL midrst_ctrl: out_valid=%b in_ready=%b tw_addr=%0d, required 0 1 0", out_valid, in_ready, tw_addr);
      end
      rx_q.delete(); done_q.delete();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send_word(16'(16'h0700 + k), 1'b0);
         ed[k*W +: W] = 16'(16'h0700 + k);
      end
      go_idle();
      wait_rx(1, 50);
      repeat (10) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 1) begin
         n_fail++; $display("FAIL midrst_count: got %0d groups, required 1", rx_q.size());
      end else begin
         n_checks++;
         if (rx_q[0].data !== ed || rx_q[0].tw !== tw_pat(0) || rx_q[0].sel !== 1'b0) begin
            n_fail++; $display("FAIL midrst_group: data=%h tw=%h, required %h %h", rx_q[0].data, rx_q[0].tw, ed, tw_pat(0));
         end
      end
   endtask

   task automatic test_random();
      bit fin;
      int nbad;
      fin = 1'b0;
      nbad = 0;
      apply_reset();
      fork
         begin
            for (int g = 0; g < 1000; g++)
               for (int k = 0; k < 8; k++) begin
                  repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 1'b0; end
                  send_word(16'($urandom), 1'($urandom_range(0, 1)));
               end
            go_idle();
            fin = 1'b1;
         end
         begin
            while (!fin) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_rx(1000, 500);
      n_checks++;
      if (rx_q.size() != 1000 || done_q.size() != 1000 || underflow != 0) begin
         n_fail++; $display("FAIL rand_count: rx=%0d model=%0d underflow=%0d, required 1000 1000 0", rx_q.size(), done_q.size(), underflow);
      end else begin
         for (int i = 0; i < 1000; i++) begin
            n_checks++;
            if (rx_q[i].data !== done_q[i].data || rx_q[i].sel !== done_q[i].sel ||
                rx_q[i].tw !== tw_pat(done_q[i].grp) || done_q[i].grp != i % NG) begin
               n_fail++; nbad++;
               if (nbad < 10) $display("FAIL rand_group%0d: data=%h sel=%b tw=%h, required %h %b %h", i, rx_q[i].data, rx_q[i].sel, rx_q[i].tw, done_q[i].data, done_q[i].sel, tw_pat(i % NG));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mode();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
